sequenciador_rodadas: RTL and testbench
=======================================

# sequenciador_rodadas

Round sequencer for the memory game. It replaces single-pass play with growing rounds. In round r it replays memory positions 0..r on the LEDs, then collects r+1 player moves in order, and advances to the next round until all N_JOGADAS positions are matched. It owns the memory address counter, the round counter and a single shared phase timer. It drives the existing datapath's memory address and jogada register, and receives the comparison result back from it.

## Interface
- N_JOGADAS, 16: sequence length and number of rounds; must be ≥ 2. Address width W = $clog2(N_JOGADAS).
- T_LED, 1000: cycles the LED is shown per position.
- T_APAGADO, 500: dark-gap cycles after each shown position.
- T_TIMEOUT, 5000: cycles allowed per player move.
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- iniciar  in  1  start/restart request, level-sampled.
- jogada_valida  in  1  one-cycle pulse: player pressed a button.
- jogada_igual  in  1  datapath compare of current move vs mem[endereco]; valid in the same cycle as jogada_valida.
- endereco  out  W  memory address currently shown or expected.
- rodada  out  W  current round index (round r has r+1 positions).
- mostra_led  out  1  drive LEDs with mem[endereco].
- registra_jogada  out  1  load the jogada register.
- pronto  out  1  game over (ganhou, perdeu or timeout).
- ganhou, perdeu, timeout  out  1  result flags.
- db_estado  out  4  state code for the 7-segment debug display.

## Operation
States and db_estado codes:
- OCIOSO (0): wait. If iniciar=1, go to PREPARA.
- PREPARA (1): clear rodada, endereco and timer. Go to MOSTRA.
- MOSTRA (2): mostra_led=1; timer counts.
  - When timer==T_LED-1: clear timer, go to APAGADO.
- APAGADO (3): timer counts.
  - When timer==T_APAGADO-1 and endereco==rodada: clear endereco and timer, go to ESPERA.
  - When timer==T_APAGADO-1 and endereco≠rodada: increment endereco, clear timer, go to MOSTRA.
- ESPERA (5): timer counts.
  - If jogada_valida=1 and jogada_igual=1 and endereco==rodada: go to FIM_RODADA.
  - If jogada_valida=1 and jogada_igual=1 and endereco≠rodada: increment endereco, clear timer, stay in ESPERA.
  - If jogada_valida=1 and jogada_igual=0: go to PERDEU.
  - Else if timer==T_TIMEOUT-1: go to TIMEOUT.
- FIM_RODADA (8):
  - If rodada==N_JOGADAS-1: go to GANHOU.
  - Else: increment rodada, clear endereco and timer, go to MOSTRA.
- GANHOU (C), TIMEOUT (D), PERDEU (E): pronto=1 plus the matching flag. endereco and rodada are held. If iniciar=1, go to PREPARA.
- Unused state codes: db_estado=B, next state OCIOSO.

Output and counter rules:
- mostra_led, pronto, ganhou, perdeu, timeout and db_estado are Moore outputs, decoded from the state register only.
- registra_jogada is Mealy: registra_jogada = (state==ESPERA) & jogada_valida.
- Simultaneous jogada_valida and timeout expiry: the move wins and is evaluated normally.
- jogada_valida outside ESPERA is ignored.
- The timer is wide enough for max(T_LED, T_APAGADO, T_TIMEOUT)-1 and never wraps; it is cleared on every state change.
- endereco and rodada never exceed N_JOGADAS-1, so they never wrap.

## Timing
- Reset low, asynchronous: state OCIOSO. endereco, rodada and timer are 0. All outputs are 0, including db_estado=0. Mid-game reset aborts immediately.
- The first cycle with reset high samples iniciar.
- iniciar is sampled at edge k: PREPARA at k+1, MOSTRA with endereco=0 at k+2.
- Phase durations:
  - MOSTRA lasts exactly T_LED cycles.
  - APAGADO lasts exactly T_APAGADO cycles.
  - ESPERA allows exactly T_TIMEOUT cycles per move; the timer restarts after each correct move.
- Correct last move of a round: FIM_RODADA for 1 cycle, then MOSTRA, or GANHOU when the final round is done.
- Wrong move: PERDEU on the next edge. endereco keeps the failing position.

## Test plan
Bench parameters: N_JOGADAS=4, T_LED=3, T_APAGADO=2, T_TIMEOUT=8.
1. Start: pulse iniciar -> PREPARA 1 cycle; mostra_led=1 for 3 cycles with endereco=0; dark 2 cycles; ESPERA with endereco=0 and rodada=0.
2. Full win: always answer correctly -> the rounds show 1, 2, 3, 4 positions with rodada 0→3; after the 4th correct move of round 3: FIM_RODADA, then GANHOU with pronto=1, ganhou=1, db_estado=C.
3. Wrong move in round 2 at endereco=1 (jogada_igual=0) -> registra_jogada=1 that cycle; next cycle perdeu=1, db_estado=E, endereco=1, rodada=2.
4. Timeout: no move in ESPERA -> ESPERA lasts 8 cycles, then timeout=1, db_estado=D. Repeat with jogada_valida=1 and jogada_igual=1 exactly at timer=7 -> move accepted, no timeout.
5. Reset low during MOSTRA in round 1 -> all outputs 0 immediately; after release, iniciar restarts from rodada=0.
6. Restart from GANHOU: iniciar=1 -> PREPARA, then MOSTRA with rodada=0 and endereco=0; flags clear.

Source files
------------

// File: rtl/sequenciador_rodadas_if.sv
// Handshake and status bundle between the round sequencer and the game datapath/panel.
interface sequenciador_rodadas_if #(
  parameter int N_JOGADAS = 16
);
  localparam int W = $clog2(N_JOGADAS);

  logic         iniciar;
  logic         jogada_valida;
  logic         jogada_igual;
  logic [W-1:0] endereco;
  logic [W-1:0] rodada;
  logic         mostra_led;
  logic         registra_jogada;
  logic         pronto;
  logic         ganhou;
  logic         perdeu;
  logic         timeout;
  logic [3:0]   db_estado;

  modport master (
    output iniciar, jogada_valida, jogada_igual,
    input  endereco, rodada, mostra_led, registra_jogada,
    input  pronto, ganhou, perdeu, timeout, db_estado
  );

  modport slave (
    input  iniciar, jogada_valida, jogada_igual,
    output endereco, rodada, mostra_led, registra_jogada,
    output pronto, ganhou, perdeu, timeout, db_estado
  );
endinterface

// File: rtl/sequenciador_rodadas.sv
// Round sequencer for the memory game: replays positions 0..r, collects r+1 moves,
// advances rounds until all N_JOGADAS positions are matched.
module sequenciador_rodadas #(
  parameter int N_JOGADAS = 16,
  parameter int T_LED     = 1000,
  parameter int T_APAGADO = 500,
  parameter int T_TIMEOUT = 5000
) (
  input logic                  clock,
  input logic                  reset,
  sequenciador_rodadas_if.slave bus
);
  localparam int W     = $clog2(N_JOGADAS);
  localparam int T_MAX = (T_LED > T_APAGADO) ?
                         ((T_LED > T_TIMEOUT) ? T_LED : T_TIMEOUT) :
                         ((T_APAGADO > T_TIMEOUT) ? T_APAGADO : T_TIMEOUT);
  localparam int TW    = (T_MAX > 1) ? $clog2(T_MAX) : 1;

  localparam logic [W-1:0]  ULTIMO      = W'(N_JOGADAS - 1);
  localparam logic [W-1:0]  W_UM        = W'(32'd1);
  localparam logic [TW-1:0] T_UM        = TW'(32'd1);
  localparam logic [TW-1:0] FIM_LED     = TW'(T_LED - 1);
  localparam logic [TW-1:0] FIM_APAGADO = TW'(T_APAGADO - 1);
  localparam logic [TW-1:0] FIM_ESPERA  = TW'(T_TIMEOUT - 1);

  // Encodings double as the debug display codes.
  typedef enum logic [3:0] {
    ST_OCIOSO     = 4'h0,
    ST_PREPARA    = 4'h1,
    ST_MOSTRA     = 4'h2,
    ST_APAGADO    = 4'h3,
    ST_ESPERA     = 4'h5,
    ST_FIM_RODADA = 4'h8,
    ST_GANHOU     = 4'hC,
    ST_TIMEOUT    = 4'hD,
    ST_PERDEU     = 4'hE
  } estado_t;

  estado_t       state_r;
  estado_t       state_next_s;
  logic [W-1:0]  endereco_r;
  logic [W-1:0]  rodada_r;
  logic [TW-1:0] timer_r;

  logic limpa_timer_s;
  logic conta_timer_s;
  logic limpa_end_s;
  logic inc_end_s;
  logic limpa_rod_s;
  logic inc_rod_s;

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r <= ST_OCIOSO;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state and counter control
  always_comb begin
    state_next_s  = state_r;
    limpa_timer_s = 1'b0;
    conta_timer_s = 1'b0;
    limpa_end_s   = 1'b0;
    inc_end_s     = 1'b0;
    limpa_rod_s   = 1'b0;
    inc_rod_s     = 1'b0;
    case (state_r)
      ST_OCIOSO: begin
        if (bus.iniciar) begin
          state_next_s = ST_PREPARA;
        end else begin
          state_next_s = ST_OCIOSO;
        end
      end
      ST_PREPARA: begin
        limpa_timer_s = 1'b1;
        limpa_end_s   = 1'b1;
        limpa_rod_s   = 1'b1;
        state_next_s  = ST_MOSTRA;
      end
      ST_MOSTRA: begin
        if (timer_r == FIM_LED) begin
          limpa_timer_s = 1'b1;
          state_next_s  = ST_APAGADO;
        end else begin
          conta_timer_s = 1'b1;
        end
      end
      ST_APAGADO: begin
        if (timer_r != FIM_APAGADO) begin
          conta_timer_s = 1'b1;
        end else if (endereco_r == rodada_r) begin
          limpa_timer_s = 1'b1;
          limpa_end_s   = 1'b1;
          state_next_s  = ST_ESPERA;
        end else begin
          limpa_timer_s = 1'b1;
          inc_end_s     = 1'b1;
          state_next_s  = ST_MOSTRA;
        end
      end
      ST_ESPERA: begin
        // A move arriving on the expiry cycle takes priority over the timeout.
        if (bus.jogada_valida && bus.jogada_igual) begin
          limpa_timer_s = 1'b1;
          if (endereco_r == rodada_r) begin
            state_next_s = ST_FIM_RODADA;
          end else begin
            inc_end_s = 1'b1;
          end
        end else if (bus.jogada_valida) begin
          limpa_timer_s = 1'b1;
          state_next_s  = ST_PERDEU;
        end else if (timer_r == FIM_ESPERA) begin
          limpa_timer_s = 1'b1;
          state_next_s  = ST_TIMEOUT;
        end else begin
          conta_timer_s = 1'b1;
        end
      end
      ST_FIM_RODADA: begin
        limpa_timer_s = 1'b1;
        if (rodada_r == ULTIMO) begin
          state_next_s = ST_GANHOU;
        end else begin
          inc_rod_s    = 1'b1;
          limpa_end_s  = 1'b1;
          state_next_s = ST_MOSTRA;
        end
      end
      ST_GANHOU, ST_TIMEOUT, ST_PERDEU: begin
        if (bus.iniciar) begin
          state_next_s = ST_PREPARA;
        end else begin
          state_next_s = state_r;
        end
      end
      default: begin
        limpa_timer_s = 1'b1;
        state_next_s  = ST_OCIOSO;
      end
    endcase
  end

  // Address, round and shared phase timer
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      endereco_r <= {W{1'b0}};
      rodada_r   <= {W{1'b0}};
      timer_r    <= {TW{1'b0}};
    end else begin
      if (limpa_end_s) begin
        endereco_r <= {W{1'b0}};
      end else if (inc_end_s) begin
        endereco_r <= endereco_r + W_UM;
      end else begin
        endereco_r <= endereco_r;
      end

      if (limpa_rod_s) begin
        rodada_r <= {W{1'b0}};
      end else if (inc_rod_s) begin
        rodada_r <= rodada_r + W_UM;
      end else begin
        rodada_r <= rodada_r;
      end

      if (limpa_timer_s || (state_next_s != state_r)) begin
        timer_r <= {TW{1'b0}};
      end else if (conta_timer_s) begin
        timer_r <= timer_r + T_UM;
      end else begin
        timer_r <= timer_r;
      end
    end
  end

  // Moore outputs from the state register; registra_jogada is the only Mealy term
  always_comb begin
    bus.mostra_led      = 1'b0;
    bus.pronto          = 1'b0;
    bus.ganhou          = 1'b0;
    bus.perdeu          = 1'b0;
    bus.timeout         = 1'b0;
    bus.db_estado       = 4'hB;
    bus.registra_jogada = (state_r == ST_ESPERA) & bus.jogada_valida;
    case (state_r)
      ST_OCIOSO:     bus.db_estado = 4'h0;
      ST_PREPARA:    bus.db_estado = 4'h1;
      ST_MOSTRA: begin
        bus.db_estado  = 4'h2;
        bus.mostra_led = 1'b1;
      end
      ST_APAGADO:    bus.db_estado = 4'h3;
      ST_ESPERA:     bus.db_estado = 4'h5;
      ST_FIM_RODADA: bus.db_estado = 4'h8;
      ST_GANHOU: begin
        bus.db_estado = 4'hC;
        bus.pronto    = 1'b1;
        bus.ganhou    = 1'b1;
      end
      ST_TIMEOUT: begin
        bus.db_estado = 4'hD;
        bus.pronto    = 1'b1;
        bus.timeout   = 1'b1;
      end
      ST_PERDEU: begin
        bus.db_estado = 4'hE;
        bus.pronto    = 1'b1;
        bus.perdeu    = 1'b1;
      end
      default:       bus.db_estado = 4'hB;
    endcase
  end

  assign bus.endereco = endereco_r;
  assign bus.rodada   = rodada_r;

endmodule

// File: tb/tb_sequenciador_rodadas.sv
// Self-checking bench: a start-up vector table, hand-written corner sequences and
// randomized games checked against a round/phase timeline model.
module tb_sequenciador_rodadas;
  localparam int N  = 4;
  localparam int TL = 3;
  localparam int TA = 2;
  localparam int TT = 8;

  localparam logic [3:0] C_OCIOSO  = 4'h0;
  localparam logic [3:0] C_PREPARA = 4'h1;
  localparam logic [3:0] C_MOSTRA  = 4'h2;
  localparam logic [3:0] C_APAGADO = 4'h3;
  localparam logic [3:0] C_ESPERA  = 4'h5;
  localparam logic [3:0] C_FIM     = 4'h8;
  localparam logic [3:0] C_GANHOU  = 4'hC;
  localparam logic [3:0] C_TIMEOUT = 4'hD;
  localparam logic [3:0] C_PERDEU  = 4'hE;

  logic  clock = 1'b0;
  logic  reset;
  int    tests = 0;
  int    fails = 0;
  string fase  = "init";

  logic [3:0] exp_code_g = 4'h0;
  int         exp_e_g    = 0;
  int         exp_r_g    = 0;

  typedef struct {
    logic       ini;
    logic       jv;
    logic       ji;
    logic       rg;
    logic [3:0] code;
    int         e;
    int         r;
  } vec_t;

  vec_t tabela[$];

  sequenciador_rodadas_if #(.N_JOGADAS(N)) bus ();

  sequenciador_rodadas #(
    .N_JOGADAS(N), .T_LED(TL), .T_APAGADO(TA), .T_TIMEOUT(TT)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nome, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s [%s] got %0d expected %0d at %0t", nome, fase, got, exp, $time);
    end
  endtask

  // {mostra_led, pronto, ganhou, timeout, perdeu} implied by a state code
  function automatic int flags_of(input logic [3:0] code);
    int f;
    f = 0;
    if (code == C_MOSTRA)  f = f + 16;
    if (code == C_GANHOU || code == C_TIMEOUT || code == C_PERDEU) f = f + 8;
    if (code == C_GANHOU)  f = f + 4;
    if (code == C_TIMEOUT) f = f + 2;
    if (code == C_PERDEU)  f = f + 1;
    return f;
  endfunction

  function automatic logic rb(input bit en);
    logic v;
    v = en ? 1'($urandom_range(0, 1)) : 1'b0;
    return v;
  endfunction

  task automatic check_state(input logic [3:0] code, input int e, input int r);
    chk("db_estado", int'(bus.db_estado), int'(code));
    chk("flags", int'({bus.mostra_led, bus.pronto, bus.ganhou, bus.timeout, bus.perdeu}),
        flags_of(code));
    if (e >= 0) chk("endereco", int'(bus.endereco), e);
    if (r >= 0) chk("rodada", int'(bus.rodada), r);
  endtask

  task automatic check_zero();
    chk("reset_outputs", int'({bus.endereco, bus.rodada, bus.mostra_led, bus.registra_jogada,
        bus.pronto, bus.ganhou, bus.perdeu, bus.timeout, bus.db_estado}), 0);
  endtask

  // One clock: drive inputs, check the Mealy output, clock, check the new state.
  task automatic st(input logic ini, input logic jv, input logic ji, input logic rg,
                    input logic [3:0] code, input int e, input int r);
    bus.iniciar       = ini;
    bus.jogada_valida = jv;
    bus.jogada_igual  = ji;
    #1;
    chk("registra_jogada", int'(bus.registra_jogada), int'(rg));
    @(posedge clock);
    #1;
    bus.iniciar       = 1'b0;
    bus.jogada_valida = 1'b0;
    bus.jogada_igual  = 1'b0;
    check_state(code, e, r);
    exp_code_g = code;
    if (e >= 0) exp_e_g = e;
    if (r >= 0) exp_r_g = r;
  endtask

  task automatic apply_reset();
    reset             = 1'b0;
    bus.iniciar       = 1'b0;
    bus.jogada_valida = 1'b0;
    bus.jogada_igual  = 1'b0;
    #1;
    check_zero();
    repeat (2) @(posedge clock);
    #1;
    check_zero();
    reset = 1'b1;
  endtask

  // Round r replays positions 0..r, then the bench sees ESPERA at position 0.
  task automatic mostra_rodada(input int r, input bit ruido);
    for (int p = 0; p <= r; p++) begin
      repeat (TL) st(rb(ruido), rb(ruido), rb(ruido), 1'b0, C_MOSTRA, p, r);
      repeat (TA) st(rb(ruido), rb(ruido), rb(ruido), 1'b0, C_APAGADO, p, r);
    end
    st(rb(ruido), rb(ruido), rb(ruido), 1'b0, C_ESPERA, 0, r);
  endtask

  // Player waits d cycles (d == TT means never answers), then presses.
  task automatic jogada(input int p, input int r, input int d, input bit certo,
                        input bit ruido, output bit fim);
    fim = 1'b0;
    for (int k = 1; k <= d; k++)
      st(rb(ruido), 1'b0, 1'b0, 1'b0, (k < TT) ? C_ESPERA : C_TIMEOUT, p, r);
    if (d >= TT) begin
      fim = 1'b1;
    end else if (!certo) begin
      st(1'b0, 1'b1, 1'b0, 1'b1, C_PERDEU, p, r);
      fim = 1'b1;
    end else if (p < r) begin
      st(1'b0, 1'b1, 1'b1, 1'b1, C_ESPERA, p + 1, r);
    end else begin
      st(1'b0, 1'b1, 1'b1, 1'b1, C_FIM, r, r);
      if (r == N - 1) begin
        st(1'b0, 1'b0, 1'b0, 1'b0, C_GANHOU, r, r);
        fim = 1'b1;
      end
    end
  endtask

  task automatic rodadas_certas(input int n_rod);
    bit fim;
    for (int r = 0; r < n_rod; r++) begin
      mostra_rodada(r, 1'b0);
      for (int p = 0; p <= r; p++) jogada(p, r, p % 3, 1'b1, 1'b0, fim);
    end
  endtask

  task automatic jogo_aleatorio();
    bit fim;
    bit certo;
    int d;
    fim = 1'b0;
    st(1'b1, 1'b0, 1'b0, 1'b0, C_PREPARA, -1, -1);
    for (int r = 0; r < N && !fim; r++) begin
      mostra_rodada(r, 1'b1);
      for (int p = 0; p <= r && !fim; p++) begin
        certo = ($urandom_range(0, 9) != 0);
        d     = ($urandom_range(0, 11) == 0) ? TT : int'($urandom_range(0, TT - 1));
        jogada(p, r, d, certo, 1'b1, fim);
      end
    end
    repeat (2) st(1'b0, rb(1'b1), rb(1'b1), 1'b0, exp_code_g, exp_e_g, exp_r_g);
  endtask

  function automatic void add(input logic ini, input logic jv, input logic ji, input logic rg,
                              input logic [3:0] code, input int e, input int r);
    vec_t v;
    v.ini = ini; v.jv = jv; v.ji = ji; v.rg = rg; v.code = code; v.e = e; v.r = r;
    tabela.push_back(v);
  endfunction

  initial begin
    bit fim;

    // Start-up and first two rounds, with ignored inputs mixed in
    add(1'b1, 1'b0, 1'b0, 1'b0, C_PREPARA, 0, 0);
    repeat (TL) add(1'b0, 1'b0, 1'b0, 1'b0, C_MOSTRA, 0, 0);
    repeat (TA) add(1'b0, 1'b0, 1'b0, 1'b0, C_APAGADO, 0, 0);
    add(1'b1, 1'b0, 1'b0, 1'b0, C_ESPERA, 0, 0);
    add(1'b0, 1'b1, 1'b1, 1'b1, C_FIM, 0, 0);
    add(1'b0, 1'b0, 1'b0, 1'b0, C_MOSTRA, 0, 1);
    add(1'b0, 1'b1, 1'b0, 1'b0, C_MOSTRA, 0, 1);
    add(1'b1, 1'b0, 1'b0, 1'b0, C_MOSTRA, 0, 1);
    repeat (TA) add(1'b0, 1'b0, 1'b0, 1'b0, C_APAGADO, 0, 1);
    repeat (TL) add(1'b0, 1'b0, 1'b0, 1'b0, C_MOSTRA, 1, 1);
    repeat (TA) add(1'b0, 1'b0, 1'b0, 1'b0, C_APAGADO, 1, 1);
    add(1'b0, 1'b0, 1'b0, 1'b0, C_ESPERA, 0, 1);
    add(1'b0, 1'b1, 1'b1, 1'b1, C_ESPERA, 1, 1);
    add(1'b0, 1'b1, 1'b1, 1'b1, C_FIM, 1, 1);
    add(1'b0, 1'b0, 1'b0, 1'b0, C_MOSTRA, 0, 2);

    fase = "reset";
    apply_reset();
    fase = "idle";
    st(1'b0, 1'b1, 1'b1, 1'b0, C_OCIOSO, 0, 0);

    fase = "tabela";
    for (int i = 0; i < tabela.size(); i++)
      st(tabela[i].ini, tabela[i].jv, tabela[i].ji, tabela[i].rg,
         tabela[i].code, tabela[i].e, tabela[i].r);

    fase = "vitoria";
    apply_reset();
    st(1'b1, 1'b0, 1'b0, 1'b0, C_PREPARA, 0, 0);
    rodadas_certas(N);
    repeat (2) st(1'b0, 1'b1, 1'b0, 1'b0, C_GANHOU, N - 1, N - 1);

    fase = "reinicio";
    st(1'b1, 1'b0, 1'b0, 1'b0, C_PREPARA, -1, -1);
    st(1'b0, 1'b0, 1'b0, 1'b0, C_MOSTRA, 0, 0);

    fase = "erro";
    apply_reset();
    st(1'b1, 1'b0, 1'b0, 1'b0, C_PREPARA, 0, 0);
    rodadas_certas(2);
    mostra_rodada(2, 1'b0);
    jogada(0, 2, 1, 1'b1, 1'b0, fim);
    jogada(1, 2, 0, 1'b0, 1'b0, fim);
    chk("erro_fim", int'(fim), 1);
    repeat (2) st(1'b0, 1'b0, 1'b0, 1'b0, C_PERDEU, 1, 2);

    fase = "timeout";
    st(1'b1, 1'b0, 1'b0, 1'b0, C_PREPARA, -1, -1);
    mostra_rodada(0, 1'b0);
    jogada(0, 0, TT, 1'b1, 1'b0, fim);
    st(1'b0, 1'b0, 1'b0, 1'b0, C_TIMEOUT, 0, 0);

    fase = "jogada_no_limite";
    st(1'b1, 1'b0, 1'b0, 1'b0, C_PREPARA, -1, -1);
    mostra_rodada(0, 1'b0);
    jogada(0, 0, TT - 1, 1'b1, 1'b0, fim);
    mostra_rodada(1, 1'b0);
    jogada(0, 1, TT - 1, 1'b1, 1'b0, fim);
    jogada(1, 1, TT - 1, 1'b1, 1'b0, fim);
    st(1'b0, 1'b0, 1'b0, 1'b0, C_MOSTRA, 0, 2);

    fase = "reset_meio";
    apply_reset();
    st(1'b1, 1'b0, 1'b0, 1'b0, C_PREPARA, 0, 0);
    rodadas_certas(1);
    st(1'b0, 1'b0, 1'b0, 1'b0, C_MOSTRA, 0, 1);
    st(1'b0, 1'b0, 1'b0, 1'b0, C_MOSTRA, 0, 1);
    reset = 1'b0;
    #2;
    check_zero();
    @(posedge clock);
    #1;
    check_zero();
    reset = 1'b1;
    st(1'b1, 1'b0, 1'b0, 1'b0, C_PREPARA, 0, 0);
    st(1'b0, 1'b0, 1'b0, 1'b0, C_MOSTRA, 0, 0);

    fase = "aleatorio";
    apply_reset();
    for (int g = 0; g < 30; g++) jogo_aleatorio();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
